cram_port_arb: RTL and testbench

- Arbitrates between the core's instruction-fetch port and its load/store port, and drives the code-RAM (SPRAM, 0x00000000, 64 KB) strobe interface.
- Only one of ccs/dcs is ever asserted in a cycle. Out-of-range accesses are blocked before they reach the RAM.
- Returns the RAM's registered read data to the requesting port with a valid/ready handshake. A one-entry hold register covers consumer back-pressure.

---
 rtl/cram_port_arb.sv | 159 +++++++++++++++
 tb/tb_cram_port_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_port_arb.sv
// -----------------------------------------------------------------------------
// cram_port_arb
//   Arbitrates the core's instruction-fetch port and load/store port onto the
//   code-RAM strobe interface (64 KB SPRAM at address 0). At most one RAM
//   access is outstanding. Its registered read data is returned to the
//   requester with a valid/ready handshake. A one-entry hold register keeps
//   the response while the consumer is not ready.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   f_req/f_adrs/f_gnt            fetch request, byte address, accept
//   f_rvalid/f_rdata/f_err        fetch response (f_err = out-of-range)
//   f_rready                      fetch consumer ready
//   d_req/d_we/d_wst/d_adrs/
//   d_wdata/d_gnt                 data request (write, strobes, addr, data)
//   d_rvalid/d_rdata/d_err        data response (rdata = 0 for writes)
//   d_rready                      data consumer ready
//   ccs/cadrs                     RAM code-port strobe and address
//   dcs/drd/dwe/dwst/dadrs/din    RAM data-port strobes, address, write data
//   ram_dout                      RAM read data, valid one cycle after strobe
// -----------------------------------------------------------------------------
module cram_port_arb #(
   parameter int XLEN = 32,
   parameter int AW   = 16,
   parameter int FAIR = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [XLEN-1:0]   f_adrs,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [XLEN-1:0]   f_rdata,
   output logic              f_err,
   input  logic              f_rready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_wst,
   input  logic [XLEN-1:0]   d_adrs,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_err,
   input  logic              d_rready,
   output logic              ccs,
   output logic [XLEN-1:0]   cadrs,
   output logic              dcs,
   output logic              drd,
   output logic              dwe,
   output logic [XLEN/8-1:0] dwst,
   output logic [XLEN-1:0]   dadrs,
   output logic [XLEN-1:0]   din,
   input  logic [XLEN-1:0]   ram_dout
);

   localparam int CW = $clog2(FAIR + 1);

   typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

   state_t            state_q, state_d;
   logic              src_q, src_d;      // 1 = data port owns the response
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   hold_q, hold_d;

   logic              f_oor, d_oor;
   logic              resp_rdy;
   logic              win;
   logic              fetch_wins;
   logic [XLEN-1:0]   resp_data;
   logic [XLEN-1:0]   rdata;
   logic              busy;

   assign f_oor      = |f_adrs[XLEN-1:AW];
   assign d_oor      = |d_adrs[XLEN-1:AW];
   assign resp_rdy   = src_q ? d_rready : f_rready;
   assign resp_data  = (err_q | we_q) ? '0 : ram_dout;
   // Grants are also suppressed while reset is held so every strobe reads 0.
   assign win        = ~rst & ((state_q == IDLE) | ((state_q == RESP) & resp_rdy));
   assign fetch_wins = f_req & (~d_req | (cnt_q == CW'(FAIR)));
   assign f_gnt      = win & fetch_wins;
   assign d_gnt      = win & d_req & ~fetch_wins;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         err_q   <= err_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      err_d   = err_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: if (f_gnt | d_gnt) state_d = RESP;
         RESP: begin
            if (resp_rdy) begin
               state_d = (f_gnt | d_gnt) ? RESP : IDLE;
            end else begin
               state_d = HOLD;
               hold_d  = resp_data;
            end
         end
         HOLD: if (resp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (f_gnt) begin
         src_d = 1'b0;
         err_d = f_oor;
         we_d  = 1'b0;
         cnt_d = '0;
      end else if (d_gnt) begin
         src_d = 1'b1;
         err_d = d_oor;
         we_d  = d_we;
         if (f_req && (cnt_q != CW'(FAIR))) cnt_d = cnt_q + CW'(1);
      end
   end

   // Outputs
   always_comb begin
      busy     = (state_q != IDLE);
      rdata    = (state_q == HOLD) ? hold_q : resp_data;
      f_rvalid = busy & ~src_q;
      d_rvalid = busy & src_q;
      f_rdata  = f_rvalid ? rdata : '0;
      d_rdata  = d_rvalid ? rdata : '0;
      f_err    = f_rvalid & err_q;
      d_err    = d_rvalid & err_q;
      ccs      = f_gnt & ~f_oor;
      cadrs    = f_adrs;
      dcs      = d_gnt & ~d_oor;
      drd      = dcs & ~d_we;
      dwe      = dcs & d_we;
      dwst     = dcs ? d_wst : '0;
      dadrs    = d_adrs;
      din      = d_wdata;
   end

endmodule

// File: tb/tb_cram_port_arb.sv
module tb_cram_port_arb;

   localparam int FAIR = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, f_gnt, f_rvalid, f_err, f_rready;
   logic [31:0] f_adrs, f_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err, d_rready;
   logic [3:0]  d_wst;
   logic [31:0] d_adrs, d_wdata, d_rdata;
   logic        ccs, dcs, drd, dwe;
   logic [3:0]  dwst;
   logic [31:0] cadrs, dadrs, din, ram_dout;

   cram_port_arb #(.XLEN(32), .AW(16), .FAIR(FAIR)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_adrs(f_adrs), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err), .f_rready(f_rready),
      .d_req(d_req), .d_we(d_we), .d_wst(d_wst), .d_adrs(d_adrs),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err), .d_rready(d_rready),
      .ccs(ccs), .cadrs(cadrs), .dcs(dcs), .drd(drd), .dwe(dwe),
      .dwst(dwst), .dadrs(dadrs), .din(din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // RAM environment: registered read, byte-strobed write, low 16 address
   // bits only (so a leaked out-of-range write aliases onto real words).
   // Unstrobed cycles put garbage on ram_dout.
   bit [31:0] mem [16384];
   always @(posedge clk) begin
      if (ccs)      ram_dout <= mem[cadrs[15:2]];
      else if (drd) ram_dout <= mem[dadrs[15:2]];
      else          ram_dout <= $urandom;
      if (dwe)
         for (int b = 0; b < 4; b++)
            if (dwst[b]) mem[dadrs[15:2]][8*b +: 8] = din[8*b +: 8];
   end

   // Reference model: one outstanding access; data wins unless fetch alone or
   // FAIR data grants have gone by while fetch waited.
   typedef struct { bit src; bit err; logic [31:0] data; } exp_t;
   exp_t      q[$];
   bit [31:0] shadow [16384];
   bit        outs, first, msrc;
   int        cnt;

   function automatic bit oor(input logic [31:0] a);
      return |a[31:16];
   endfunction

   always @(negedge clk) begin : monitor
      bit   hs, win, ef, ed, eccs, edcs;
      exp_t e;
      if (rst) begin
         q.delete(); outs = 0; first = 0; cnt = 0;
      end else begin
         hs   = outs && (msrc ? d_rready : f_rready);
         win  = !outs || (hs && first);
         ef   = win && f_req && (!d_req || cnt == FAIR);
         ed   = win && d_req && !ef;
         eccs = ef && !oor(f_adrs);
         edcs = ed && !oor(d_adrs);
         chk("f_gnt", f_gnt, ef);
         chk("d_gnt", d_gnt, ed);
         chk("f_rvalid", f_rvalid, outs && !msrc);
         chk("d_rvalid", d_rvalid, outs && msrc);
         chk("ccs", ccs, eccs);
         chk("dcs", dcs, edcs);
         chk("drd", drd, edcs && !d_we);
         chk("dwe", dwe, edcs && d_we);
         chk("dwst", dwst, edcs ? d_wst : 4'b0);
         if (eccs) chk("cadrs", cadrs, f_adrs);
         if (edcs) begin
            chk("dadrs", dadrs, d_adrs);
            if (d_we) chk("din", din, d_wdata);
         end
         if (hs) begin
            if (q.size() == 0) chk("resp_queue_empty", 1, 0);
            else begin
               e = q.pop_front();
               chk("resp_src", msrc, e.src);
               chk(msrc ? "d_rdata" : "f_rdata", msrc ? d_rdata : f_rdata, e.data);
               chk(msrc ? "d_err" : "f_err", msrc ? d_err : f_err, e.err);
            end
            outs = 0;
         end else if (outs) first = 0;
         if (ef) begin
            e.src = 0; e.err = oor(f_adrs);
            e.data = e.err ? 32'h0 : shadow[f_adrs[15:2]];
            q.push_back(e);
            cnt = 0;
         end else if (ed) begin
            e.src = 1; e.err = oor(d_adrs);
            e.data = (e.err || d_we) ? 32'h0 : shadow[d_adrs[15:2]];
            q.push_back(e);
            if (!e.err && d_we)
               for (int b = 0; b < 4; b++)
                  if (d_wst[b]) shadow[d_adrs[15:2]][8*b +: 8] = d_wdata[8*b +: 8];
            if (f_req && cnt < FAIR) cnt++;
         end
         if (ef || ed) begin outs = 1; first = 1; msrc = ed; end
      end
   end

   // Driver helpers: sample grants at negedge, change inputs just after posedge.
   bit fg, dg;
   task automatic cycle();
      @(negedge clk); fg = f_gnt; dg = d_gnt;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_fetch(input logic [31:0] a);
      int n = 0;
      f_req = 1; f_adrs = a;
      do begin cycle(); n++; end while (!fg && n < 20);
      chk("fetch_gnt_timeout", fg, 1);
      f_req = 0;
   endtask

   task automatic do_data(input bit we, input logic [3:0] st, input logic [31:0] a,
                          input logic [31:0] wd);
      int n = 0;
      d_req = 1; d_we = we; d_wst = st; d_adrs = a; d_wdata = wd;
      do begin cycle(); n++; end while (!dg && n < 20);
      chk("data_gnt_timeout", dg, 1);
      d_req = 0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err, ccs, dcs, drd, dwe, dwst}, 0);
      chk({nm, "_rdata"}, {f_rdata, d_rdata}, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      int r;
      a = ($urandom % 16) << 2;
      r = $urandom % 10;
      if (r == 0) a = a | 32'h0001_0000;
      else if (r == 1) a = a | 32'h8000_0000;
      return a;
   endfunction

   initial begin
      mem[32'h100 >> 2] = 32'h0000_0013;  shadow[32'h100 >> 2] = 32'h0000_0013;
      mem[32'h200 >> 2] = 32'h1234_5678;  shadow[32'h200 >> 2] = 32'h1234_5678;
      mem[1] = 32'h0BAD_F00D;             shadow[1] = 32'h0BAD_F00D;
      rst = 1; f_req = 0; d_req = 0; d_we = 0; d_wst = 0;
      f_adrs = 0; d_adrs = 0; d_wdata = 0; f_rready = 1; d_rready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset_outputs");
      rst = 0;

      // Basic fetch, byte-strobed write then read-back, out-of-range accesses
      do_fetch(32'h0000_0100);
      idle(2);
      do_data(1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
      do_data(0, 4'b0000, 32'h0000_0200, 32'h0);
      idle(2);
      do_data(0, 4'b0000, 32'h0001_0000, 32'h0);
      do_data(1, 4'b1111, 32'h0001_0004, 32'hCAFE_F00D);
      do_data(0, 4'b0000, 32'h0000_0004, 32'h0);
      idle(2);

      // Back-pressure: response held, competing request must wait
      f_rready = 0;
      do_fetch(32'h0000_0100);
      d_req = 1; d_we = 0; d_adrs = 32'h0000_0200;
      idle(3);
      f_rready = 1;
      begin
         int n = 0;
         do begin cycle(); n++; end while (!dg && n < 20);
         chk("hold_release_timeout", dg, 1);
      end
      d_req = 0;
      idle(2);

      // Both ports saturated: D,D,D,D,F pattern
      f_req = 1; f_adrs = 32'h0000_0100;
      d_req = 1; d_we = 0; d_adrs = 32'h0000_0200;
      idle(30);
      f_req = 0; d_req = 0;
      idle(3);

      // Asynchronous reset in the middle of a response
      f_rready = 0;
      do_fetch(32'h0000_0100);
      #2 rst = 1;
      #1 chk_all_zero("async_reset");
      @(posedge clk);
      #3 rst = 0;
      f_rready = 1;
      idle(2);
      do_fetch(32'h0000_0100);
      idle(3);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if (!f_req || fg) begin
            f_req = ($urandom % 100) < 60;
            f_adrs = rand_addr();
         end
         if (!d_req || dg) begin
            d_req = ($urandom % 100) < 60;
            d_we = $urandom % 2;
            d_wst = $urandom;
            d_adrs = rand_addr();
            d_wdata = $urandom;
         end
         f_rready = ($urandom % 100) < 70;
         d_rready = ($urandom % 100) < 70;
         cycle();
      end

      f_req = 0; d_req = 0; f_rready = 1; d_rready = 1;
      idle(5);
      chk("drain_queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
